// File: rtl/cycle_controller.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM_WAIT/MEM/WB with one-hot stage code.
// Latency: 4 cycles per plain instruction, +1 with register write, +1+waits with memory access.
// Backpressure: mem_ready stalls in MEM_WAIT up to TIMEOUT cycles, then aborts to IDLE with sticky err.
module cycle_controller #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        start,
  input  logic        halt,
  input  logic        stop_req,
  input  logic        mem_op,
  input  logic        mem_ready,
  input  logic        reg_write,
  output logic [5:0]  state,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic        busy,
  output logic        err,
  output logic [31:0] instr_count
);

  typedef enum logic [5:0] {
    S_IDLE  = 6'b000000,
    S_FETCH = 6'b000001,
    S_DEC   = 6'b000010,
    S_EXEC  = 6'b000100,
    S_MEMW  = 6'b001000,
    S_MEM   = 6'b010000,
    S_WB    = 6'b100000
  } state_t;

  localparam logic [3:0] TIMEOUT_CNT = TIMEOUT[3:0];

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  wait_q;
  logic [3:0]  wait_next;
  logic [31:0] count_q;
  logic        err_q;
  logic        retire;
  logic        timeout;
  logic        accept;

  // wait_next is the number of MEM_WAIT cycles spent including the current one,
  // so the abort lands after exactly TIMEOUT cycles in MEM_WAIT.
  assign wait_next = wait_q + 4'd1;

  // Next-state decode plus the retire / timeout / start-accept events.
  always_comb begin
    state_d = S_IDLE;
    retire  = 1'b0;
    timeout = 1'b0;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          accept  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: state_d = S_DEC;
      S_DEC:   state_d = halt ? S_IDLE : S_EXEC;
      S_EXEC:  state_d = mem_op ? S_MEMW : S_MEM;
      S_MEMW: begin
        if (mem_ready) begin
          state_d = S_MEM;
        end else if (wait_next == TIMEOUT_CNT) begin
          state_d = S_IDLE;
          timeout = 1'b1;
        end else begin
          state_d = S_MEMW;
        end
      end
      S_MEM: begin
        if (reg_write) begin
          state_d = S_WB;
        end else begin
          retire  = 1'b1;
          state_d = stop_req ? S_IDLE : S_FETCH;
        end
      end
      S_WB: begin
        retire  = 1'b1;
        state_d = stop_req ? S_IDLE : S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Wait counter: zero outside MEM_WAIT, counts cycles while staying there.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                                    wait_q <= 4'd0;
    else if (state_q == S_MEMW && state_d == S_MEMW) wait_q <= wait_next;
    else                                           wait_q <= 4'd0;
  end

  // Retired-instruction counter, cleared when a new run starts.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)      count_q <= 32'd0;
    else if (accept) count_q <= 32'd0;
    else if (retire) count_q <= count_q + 32'd1;
  end

  // Sticky timeout flag, cleared when a new run starts.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)       err_q <= 1'b0;
    else if (accept)  err_q <= 1'b0;
    else if (timeout) err_q <= 1'b1;
  end

  assign state       = state_q;
  assign ir_we       = (state_q == S_FETCH);
  assign pc_we       = (state_q == S_MEM);
  assign rf_we       = (state_q == S_WB);
  assign busy        = (state_q != S_IDLE);
  assign err         = err_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_cycle_controller.sv
// Randomized bench: instruction-level plan predicts stage sequence, counter and error flag.
// Latency: outputs compared on every falling edge against the planned values.
// Backpressure: mem_ready timing is chosen per instruction, including past the timeout.
module tb_cycle_controller;

  localparam int TMO = 15;
  localparam logic [5:0] IDLE  = 6'b000000;
  localparam logic [5:0] FETCH = 6'b000001;
  localparam logic [5:0] DEC   = 6'b000010;
  localparam logic [5:0] EXEC  = 6'b000100;
  localparam logic [5:0] MEMW  = 6'b001000;
  localparam logic [5:0] MEM   = 6'b010000;
  localparam logic [5:0] WB    = 6'b100000;

  logic        CLK;
  logic        RST_N;
  logic        start, halt, stop_req, mem_op, mem_ready, reg_write;
  logic [5:0]  state;
  logic        ir_we, pc_we, rf_we, busy, err;
  logic [31:0] instr_count;

  cycle_controller #(.TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .halt(halt), .stop_req(stop_req),
    .mem_op(mem_op), .mem_ready(mem_ready), .reg_write(reg_write),
    .state(state), .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we), .busy(busy),
    .err(err), .instr_count(instr_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Planned values for the current cycle.
  logic [5:0]  exp_state = IDLE;
  logic [31:0] exp_cnt   = 32'd0;
  logic        exp_err   = 1'b0;

  // Observed pulse tallies used by the literal checks.
  int pc_pulses = 0;
  int rf_pulses = 0;
  int memw_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  // Per-cycle comparison against the plan.
  always @(negedge CLK) begin
    chk("state", {26'd0, state}, {26'd0, exp_state});
    chk("ir_we", {31'd0, ir_we}, {31'd0, exp_state == FETCH});
    chk("pc_we", {31'd0, pc_we}, {31'd0, exp_state == MEM});
    chk("rf_we", {31'd0, rf_we}, {31'd0, exp_state == WB});
    chk("busy", {31'd0, busy}, {31'd0, exp_state != IDLE});
    chk("err", {31'd0, err}, {31'd0, exp_err});
    chk("instr_count", instr_count, exp_cnt);
    if (pc_we) pc_pulses++;
    if (rf_we) rf_pulses++;
    if (state == MEMW) memw_cycles++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic noise();
    start     = 1'($urandom);
    halt      = 1'($urandom);
    stop_req  = 1'($urandom);
    mem_op    = 1'($urandom);
    mem_ready = 1'($urandom);
    reg_write = 1'($urandom);
  endtask

  task automatic idle_cycle();
    noise();
    start = 1'b0;
    tick();
  endtask

  task automatic accept();
    noise();
    start = 1'b1;
    tick();
    exp_state = FETCH;
    exp_cnt   = 32'd0;
    exp_err   = 1'b0;
  endtask

  // One instruction starting in FETCH. rdy_at: MEM_WAIT cycle on which mem_ready rises
  // (0 or beyond the timeout means never). cont=1 when the next cycle is FETCH again.
  task automatic do_instr(input bit hlt, input bit mem, input bit rw, input int rdy_at,
                          input bit stp, output bit cont);
    cont = 1'b0;
    noise();
    tick();
    exp_state = DEC;
    noise();
    halt = hlt;
    tick();
    if (hlt) begin
      exp_state = IDLE;
      return;
    end
    exp_state = EXEC;
    noise();
    mem_op = mem;
    tick();
    if (mem) begin
      for (int k = 1; k <= TMO; k++) begin
        exp_state = MEMW;
        noise();
        mem_ready = (k == rdy_at);
        tick();
        if (k == rdy_at) break;
        if (k == TMO) begin
          exp_err   = 1'b1;
          exp_state = IDLE;
          return;
        end
      end
    end
    exp_state = MEM;
    noise();
    reg_write = rw;
    if (!rw) stop_req = stp;
    tick();
    if (rw) begin
      exp_state = WB;
      noise();
      stop_req = stp;
      tick();
    end
    exp_cnt   = exp_cnt + 32'd1;
    exp_state = stp ? IDLE : FETCH;
    cont      = !stp;
  endtask

  initial begin
    bit cont;
    int p0, r0, m0;
    RST_N = 1'b0;
    start = 0; halt = 0; stop_req = 0; mem_op = 0; mem_ready = 0; reg_write = 0;
    #2;
    chk("reset state", {26'd0, state}, 32'd0);
    chk("reset count", instr_count, 32'd0);
    chk("reset err", {31'd0, err}, 32'd0);
    tick();
    tick();
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) idle_cycle();

    // Plain instruction, then stays running.
    accept();
    p0 = pc_pulses;
    do_instr(0, 0, 0, 0, 0, cont);
    chk("plain count", instr_count, 32'd1);
    chk("plain next state", {26'd0, state}, {26'd0, FETCH});
    chk("plain pc pulses", pc_pulses - p0, 1);

    // Memory + register write, ready on 3rd wait cycle.
    r0 = rf_pulses; m0 = memw_cycles;
    do_instr(0, 1, 1, 3, 0, cont);
    chk("memrw count", instr_count, 32'd2);
    chk("memrw wait cycles", memw_cycles - m0, 3);
    chk("memrw rf pulses", rf_pulses - r0, 1);

    // Ready exactly on the timeout cycle wins.
    do_instr(0, 1, 0, TMO, 0, cont);
    chk("edge ready err", {31'd0, err}, 32'd0);
    chk("edge ready count", instr_count, 32'd3);

    // Timeout.
    m0 = memw_cycles;
    do_instr(0, 1, 0, 0, 0, cont);
    chk("timeout err", {31'd0, err}, 32'd1);
    chk("timeout state", {26'd0, state}, 32'd0);
    chk("timeout wait cycles", memw_cycles - m0, TMO);
    idle_cycle();
    accept();
    chk("restart err", {31'd0, err}, 32'd0);
    chk("restart count", instr_count, 32'd0);

    // Halt in DECODE.
    do_instr(0, 0, 1, 0, 0, cont);
    do_instr(1, 0, 0, 0, 0, cont);
    chk("halt state", {26'd0, state}, 32'd0);
    chk("halt busy", {31'd0, busy}, 32'd0);
    chk("halt count", instr_count, 32'd1);

    // Counter wrap.
    accept();
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    exp_cnt = 32'hFFFF_FFFF;
    do_instr(0, 0, 0, 0, 1, cont);
    chk("wrap count", instr_count, 32'd0);
    chk("wrap stop state", {26'd0, state}, 32'd0);

    // Reset in MEM.
    accept();
    do_instr(0, 0, 0, 0, 0, cont);
    noise(); tick();
    exp_state = DEC; noise(); halt = 0; tick();
    exp_state = EXEC; noise(); mem_op = 0; tick();
    exp_state = MEM;
    #1;
    chk("pre-reset state", {26'd0, state}, {26'd0, MEM});
    RST_N = 1'b0;
    exp_state = IDLE; exp_cnt = 32'd0; exp_err = 1'b0;
    #1;
    chk("mid reset state", {26'd0, state}, 32'd0);
    chk("mid reset pc_we", {31'd0, pc_we}, 32'd0);
    chk("mid reset count", instr_count, 32'd0);
    tick();
    RST_N = 1'b1;
    for (int i = 0; i < 2; i++) idle_cycle();

    // Random instruction stream.
    accept();
    for (int n = 0; n < 200; n++) begin
      do_instr(($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom),
               $urandom_range(0, 17), ($urandom_range(0, 5) == 0), cont);
      if (!cont) begin
        for (int j = $urandom_range(0, 2); j > 0; j--) idle_cycle();
        accept();
      end
    end

    @(negedge CLK);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cycle_controller.md
CYCLE_CONTROLLER -- requirements
Module: cycle_controller

Interface
REQ-001 The block SHALL have the parameter TIMEOUT, default 15, giving the maximum number of MEM_WAIT cycles before an error is flagged (legal range 1..15).
REQ-002 The block SHALL have the port CLK, input, 1 bit: the single clock, with all state updated on the rising edge.
REQ-003 The block SHALL have the port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have the port start, input, 1 bit: begins execution when in IDLE.
REQ-005 The block SHALL have the port halt, input, 1 bit: decoded halt instruction, sampled in DECODE.
REQ-006 The block SHALL have the port stop_req, input, 1 bit: external stop, honoured only at instruction boundaries.
REQ-007 The block SHALL have the port mem_op, input, 1 bit: current instruction asserts DR or DW.
REQ-008 The block SHALL have the port mem_ready, input, 1 bit: the data memory access is complete.
REQ-009 The block SHALL have the port reg_write, input, 1 bit: current instruction writes the register file.
REQ-010 The block SHALL have the port state, output, 6 bits: one-hot stage code distributed to all datapath stages.
REQ-011 The block SHALL have the port ir_we, output, 1 bit: instruction register load enable.
REQ-012 The block SHALL have the port pc_we, output, 1 bit: PC_new commit enable.
REQ-013 The block SHALL have the port rf_we, output, 1 bit: register file write enable.
REQ-014 The block SHALL have the port busy, output, 1 bit: the controller is not in IDLE.
REQ-015 The block SHALL have the port err, output, 1 bit: sticky memory-timeout error.
REQ-016 The block SHALL have the port instr_count, output, 32 bits: number of retired instructions.

Function
REQ-017 The state encodings SHALL be IDLE=000000, FETCH=000001, DECODE=000010, EXEC=000100, MEM_WAIT=001000, MEM=010000 and WB=100000.
REQ-018 IDLE SHALL go to FETCH when start=1, and SHALL otherwise hold.
REQ-019 FETCH SHALL go to DECODE unconditionally.
REQ-020 DECODE SHALL go to IDLE when halt=1 (the instruction is not retired), and SHALL otherwise go to EXEC.
REQ-021 EXEC SHALL go to MEM_WAIT when mem_op=1, and SHALL otherwise go to MEM.
REQ-022 MEM_WAIT SHALL go to MEM on the first cycle mem_ready=1.
REQ-023 MEM_WAIT SHALL compare a 4-bit wait counter against TIMEOUT each cycle:
- the counter SHALL be cleared on entry to MEM_WAIT and SHALL increment each cycle spent there;
- when the counter equals TIMEOUT with mem_ready=0, err SHALL be set and the state SHALL go to IDLE.
REQ-024 mem_ready=1 on the cycle the wait counter equals TIMEOUT SHALL take priority over the timeout: go to MEM, with no error.
REQ-025 MEM SHALL go to WB when reg_write=1; otherwise MEM SHALL be the retirement point.
REQ-026 WB SHALL be the retirement point.
REQ-027 At a retirement point, the next state SHALL be IDLE when stop_req=1, and SHALL otherwise be FETCH.
REQ-028 ir_we SHALL be 1 exactly while state=FETCH.
REQ-029 pc_we SHALL be 1 exactly while state=MEM, giving one pulse per instruction.
REQ-030 rf_we SHALL be 1 exactly while state=WB.
REQ-031 ir_we, pc_we and rf_we SHALL be decoded combinationally from the state register only, never from inputs.
REQ-032 busy SHALL equal (state != IDLE).
REQ-033 instr_count SHALL increment by 1 on each clock edge that leaves a retirement point, wrapping from FFFFFFFF to 00000000.
REQ-034 instr_count SHALL be cleared when start is accepted in IDLE.
REQ-035 err SHALL be sticky until start is accepted in IDLE, which SHALL clear it.
REQ-036 start, halt, stop_req, mem_op and reg_write SHALL be ignored in every state where they are not named above.
REQ-037 A state register value that is not one of the seven encodings SHALL go to IDLE on the next edge, without retiring or setting err.
REQ-038 A non-memory instruction SHALL take 4 cycles (FETCH, DECODE, EXEC, MEM).
REQ-039 A register-writing non-memory instruction SHALL take 5 cycles.
REQ-040 A memory instruction SHALL take 5 cycles plus its wait cycles, plus 1 if it also writes a register.

Reset
REQ-041 While RST_N=0, the outputs SHALL immediately read: state=000000, ir_we=pc_we=rf_we=0, busy=0, err=0, instr_count=0, and the wait counter SHALL be 0.
REQ-042 Reset asserted mid-instruction (any state) SHALL abort that instruction with no retirement.
REQ-043 After RST_N deasserts, the controller SHALL stay in IDLE until start=1 is sampled.

Verification
REQ-044 Reset, then pulse start, with mem_op=0 and reg_write=0 -> state sequence 000001,000010,000100,010000,000001; pc_we high 1 cycle; instr_count=1 after the MEM exit.
REQ-045 An instruction with mem_op=1 and reg_write=1, with mem_ready asserted on the 3rd MEM_WAIT cycle -> 3 cycles at 001000, then 010000, then 100000 with rf_we=1; instr_count increments once.
REQ-046 mem_op=1 with mem_ready held 0, TIMEOUT=15 -> after 15 MEM_WAIT cycles, err=1 and state=000000; the next start clears err and instr_count.
REQ-047 halt=1 in DECODE -> IDLE next cycle, instr_count unchanged, busy=0; stop_req=1 during EXEC but dropped before MEM -> no stop.
REQ-048 RST_N pulsed low while state=010000 -> outputs are immediately at their reset values; no increment of instr_count.
REQ-049 Preload instr_count to FFFFFFFF (run to wrap or force) and retire one instruction -> instr_count=00000000.
